// File: rtl/hls_dlmon_pkg.sv
// Shared types and helpers for the HLS deadlock monitor: state encoding and
// the lowest-set-index search used to latch the culprit line.
package hls_dlmon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_SUSPECT  = 2'b01,
        ST_DEADLOCK = 2'b10
    } mon_state_e;

    // Upper bound on N_AXIS+N_INST that lowest_set_idx can search.
    localparam int MAX_LINES = 64;
    localparam int MAX_IDX_W = 6;

    function automatic logic [MAX_IDX_W-1:0] lowest_set_idx(input logic [MAX_LINES-1:0] vec);
        lowest_set_idx = '0;
        for (int i = MAX_LINES - 1; i >= 0; i--) begin
            if (vec[i]) lowest_set_idx = MAX_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/hls_deadlock_monitor_param_if.sv
// Block/idle inputs and deadlock status outputs of one monitor instance.
// DLMON_TRACE_EN adds the trace_vec/trace_time capture outputs.
interface hls_deadlock_monitor_param_if #(
    parameter int N_AXIS = 7,
    parameter int N_INST = 1,
    parameter int EV_W   = 16
) ();
    localparam int IDX_W = $clog2(N_AXIS + N_INST);

    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_INST-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              clear;
    logic              block;
    logic [1:0]        mon_state;
    logic [IDX_W-1:0]  first_idx;
    logic [EV_W-1:0]   ev_count;
`ifdef DLMON_TRACE_EN
    logic [N_AXIS+N_INST-1:0] trace_vec;
    logic [31:0]              trace_time;

    modport master (output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
                    input  block, mon_state, first_idx, ev_count, trace_vec, trace_time);
    modport slave  (input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
                    output block, mon_state, first_idx, ev_count, trace_vec, trace_time);
`else
    modport master (output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
                    input  block, mon_state, first_idx, ev_count);
    modport slave  (input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
                    output block, mon_state, first_idx, ev_count);
`endif
endinterface

// File: rtl/hls_dlmon_persist.sv
// Saturating persistence counter: counts consecutive blocked cycles up to
// THRESH-1 and reports hit when that value is reached.
module hls_dlmon_persist #(
    parameter int CNT_W  = 8,
    parameter int THRESH = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic hit
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(THRESH - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                cnt <= '0;
        else if (clr)                cnt <= '0;
        else if (inc && cnt != LAST) cnt <= cnt + CNT_W'(1);
    end

    assign hit = (cnt == LAST);

endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// Deadlock monitor for one HLS instance: persistence-filtered block detection,
// culprit latch and saturating episode counter. Optional trace: DLMON_TRACE_EN.
module hls_deadlock_monitor_param
    import hls_dlmon_pkg::*;
#(
    parameter int                N_AXIS  = 7,
    parameter int                N_INST  = 1,
    parameter logic [N_AXIS-1:0] CH_MASK = {N_AXIS{1'b1}},
    parameter int                THRESH  = 1,
    parameter int                CNT_W   = 8,
    parameter int                STICKY  = 1,
    parameter int                EV_W    = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    hls_deadlock_monitor_param_if.slave  mon
);
    localparam int N_LINES = N_AXIS + N_INST;
    localparam int IDX_W   = $clog2(N_LINES);

    logic [N_LINES-1:0] blk_vec;
    logic               any_blk;
    mon_state_e         state, state_next;
    logic               cnt_inc, cnt_clr, cnt_hit;
    logic               enter_dl;
    logic               block_q;
    logic [IDX_W-1:0]   first_idx_q;
    logic [EV_W-1:0]    ev_q;

    // An idle child cannot be the one holding the pipeline up.
    assign blk_vec = {mon.inst_block_sigs & ~mon.inst_idle_sigs, mon.axis_block_sigs & CH_MASK};
    assign any_blk = |blk_vec;

    hls_dlmon_persist #(.CNT_W(CNT_W), .THRESH(THRESH)) u_persist (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (cnt_inc),
        .clr     (cnt_clr),
        .hit     (cnt_hit)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        if (mon.clear) begin
            state_next = ST_IDLE;
            cnt_clr    = 1'b1;
        end else begin
            unique case (state)
                ST_IDLE: if (any_blk) begin
                    state_next = (THRESH == 1) ? ST_DEADLOCK : ST_SUSPECT;
                    cnt_inc    = 1'b1;
                end
                ST_SUSPECT: begin
                    if (!any_blk) begin
                        state_next = ST_IDLE;
                        cnt_clr    = 1'b1;
                    end else if (cnt_hit) begin
                        state_next = ST_DEADLOCK;
                        cnt_clr    = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                ST_DEADLOCK: begin
                    cnt_clr = 1'b1;
                    if (STICKY == 0 && !any_blk) state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            endcase
        end
    end

    assign enter_dl = (state != ST_DEADLOCK) && (state_next == ST_DEADLOCK);

    // clear deliberately leaves first_idx and the episode count alone for post-mortem reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            block_q     <= 1'b0;
            first_idx_q <= '0;
            ev_q        <= '0;
        end else begin
            state   <= state_next;
            block_q <= (state_next == ST_DEADLOCK);
            if (!mon.clear && state == ST_IDLE && any_blk)
                first_idx_q <= IDX_W'(lowest_set_idx(MAX_LINES'(blk_vec)));
            if (enter_dl && ev_q != '1)
                ev_q <= ev_q + EV_W'(1);
        end
    end

    assign mon.block     = block_q;
    assign mon.mon_state = state;
    assign mon.first_idx = first_idx_q;
    assign mon.ev_count  = ev_q;

`ifdef DLMON_TRACE_EN
    logic [31:0]        cycle_cnt;
    logic [N_LINES-1:0] trace_vec_q;
    logic [31:0]        trace_time_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt    <= '0;
            trace_vec_q  <= '0;
            trace_time_q <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (enter_dl) begin
                trace_vec_q  <= blk_vec;
                trace_time_q <= cycle_cnt;
            end
        end
    end

    assign mon.trace_vec  = trace_vec_q;
    assign mon.trace_time = trace_time_q;
`endif

endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// Scoreboard bench: a sticky THRESH=4 monitor and a non-sticky THRESH=2 monitor
// with a 4-bit episode counter share one stimulus stream against a run-length model.
module tb_hls_deadlock_monitor_param;

    localparam int         NA   = 7;
    localparam int         NI   = 2;
    localparam logic [6:0] MASK = 7'b1011111;

    localparam int S_THRESH = 4, S_EVMAX = 65535;
    localparam int N_THRESH = 2, N_EVMAX = 15;

    logic       clock = 1'b0;
    logic       rst_n = 1'b1;
    logic [6:0] axis  = '0;
    logic [1:0] iblk  = '0;
    logic [1:0] iidle = '0;
    logic       clr   = 1'b0;

    hls_deadlock_monitor_param_if #(.N_AXIS(NA), .N_INST(NI), .EV_W(16)) if_s ();
    hls_deadlock_monitor_param_if #(.N_AXIS(NA), .N_INST(NI), .EV_W(4))  if_n ();

    assign if_s.axis_block_sigs = axis;
    assign if_s.inst_block_sigs = iblk;
    assign if_s.inst_idle_sigs  = iidle;
    assign if_s.clear           = clr;
    assign if_n.axis_block_sigs = axis;
    assign if_n.inst_block_sigs = iblk;
    assign if_n.inst_idle_sigs  = iidle;
    assign if_n.clear           = clr;

    hls_deadlock_monitor_param #(
        .N_AXIS(NA), .N_INST(NI), .CH_MASK(MASK), .THRESH(S_THRESH),
        .CNT_W(8), .STICKY(1), .EV_W(16)
    ) dut_s (.clock(clock), .reset_n(rst_n), .mon(if_s));

    hls_deadlock_monitor_param #(
        .N_AXIS(NA), .N_INST(NI), .CH_MASK(MASK), .THRESH(N_THRESH),
        .CNT_W(8), .STICKY(0), .EV_W(4)
    ) dut_n (.clock(clock), .reset_n(rst_n), .mon(if_n));

    always #5 clock = ~clock;

    // Model: length of the current blocked run decides when a deadlock begins.
    typedef struct {
        bit in_dl;
        int run;
        int first;
        int ev;
    } model_t;

    typedef struct {
        model_t s;
        model_t n;
    } exp_t;

    exp_t   exp_q[$];
    model_t ms, mn;
    int     n_cmp = 0;
    int     n_bad = 0;

    function automatic int lowest(input logic [8:0] v);
        for (int i = 0; i < 9; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic model_t mdl_step(input model_t m, input logic [8:0] blk, input bit c,
                                        input int thresh, input bit sticky, input int ev_max);
        if (c) begin
            m.in_dl = 0;
            m.run   = 0;
        end else if (m.in_dl) begin
            if (!sticky && blk == 0) m.in_dl = 0;
        end else if (blk != 0) begin
            if (m.run == 0) m.first = lowest(blk);
            m.run++;
            if (m.run >= thresh) begin
                m.in_dl = 1;
                m.run   = 0;
                if (m.ev < ev_max) m.ev++;
            end
        end else begin
            m.run = 0;
        end
        return m;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input model_t m, input logic blk, input logic [1:0] st,
                           input logic [3:0] idx, input logic [15:0] ev);
        logic [1:0] st_req;
        st_req = m.in_dl ? 2'b10 : (m.run > 0 ? 2'b01 : 2'b00);
        check({tag, ".block"},     32'(blk), 32'(m.in_dl));
        check({tag, ".mon_state"}, 32'(st),  32'(st_req));
        check({tag, ".first_idx"}, 32'(idx), 32'(m.first));
        check({tag, ".ev_count"},  32'(ev),  32'(m.ev));
    endtask

    task automatic step(input logic [6:0] a, input logic [1:0] b, input logic [1:0] i, input bit c);
        logic [8:0] blk;
        @(negedge clock);
        axis  = a;
        iblk  = b;
        iidle = i;
        clr   = c;
        blk   = {b & ~i, a & MASK};
        ms    = mdl_step(ms, blk, c, S_THRESH, 1'b1, S_EVMAX);
        mn    = mdl_step(mn, blk, c, N_THRESH, 1'b0, N_EVMAX);
        exp_q.push_back('{s: ms, n: mn});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".s.block"},     32'(if_s.block),     32'd0);
        check({tag, ".s.mon_state"}, 32'(if_s.mon_state), 32'd0);
        check({tag, ".s.first_idx"}, 32'(if_s.first_idx), 32'd0);
        check({tag, ".s.ev_count"},  32'(if_s.ev_count),  32'd0);
        check({tag, ".n.block"},     32'(if_n.block),     32'd0);
        check({tag, ".n.mon_state"}, 32'(if_n.mon_state), 32'd0);
        check({tag, ".n.first_idx"}, 32'(if_n.first_idx), 32'd0);
        check({tag, ".n.ev_count"},  32'(if_n.ev_count),  32'd0);
    endtask

    // Monitor: every post-reset edge produces one registered observation to score.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("s", e.s, if_s.block, if_s.mon_state, if_s.first_idx, if_s.ev_count);
                compare("n", e.n, if_n.block, if_n.mon_state, if_n.first_idx, 16'(if_n.ev_count));
            end
        end
    end

    initial begin
        int         len;
        logic [6:0] a;
        logic [1:0] bb, ii;

        ms = '{in_dl: 0, run: 0, first: 0, ev: 0};
        mn = ms;

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        rst_n = 1'b1;

        // Single culprit held: first_idx=3, sticky block four edges in.
        repeat (10) step(7'b0001000, 2'b00, 2'b00, 1'b0);
        repeat (2)  step(7'b0000000, 2'b00, 2'b00, 1'b0);
        step(7'b0000000, 2'b00, 2'b00, 1'b1);

        // Runs broken by a quiet cycle never reach THRESH=4.
        repeat (3) step(7'b0000100, 2'b00, 2'b00, 1'b0);
        step(7'b0000000, 2'b00, 2'b00, 1'b0);
        repeat (3) step(7'b0000100, 2'b00, 2'b00, 1'b0);
        step(7'b0000000, 2'b00, 2'b00, 1'b1);

        // Idle child masks its block; once busy it becomes culprit N_AXIS+1.
        repeat (3) step(7'b0000000, 2'b10, 2'b10, 1'b0);
        repeat (5) step(7'b0000000, 2'b10, 2'b00, 1'b0);

        // Sticky hold, then clear coincident with a new block.
        repeat (2) step(7'b0000000, 2'b00, 2'b00, 1'b0);
        step(7'b0000010, 2'b00, 2'b00, 1'b1);
        step(7'b0000010, 2'b00, 2'b00, 1'b0);
        step(7'b0000000, 2'b00, 2'b00, 1'b0);

        // Masked channel is ignored; axis[0] block then release.
        repeat (6) step(7'b0100000, 2'b00, 2'b00, 1'b0);
        repeat (5) step(7'b0000001, 2'b00, 2'b00, 1'b0);
        repeat (2) step(7'b0000000, 2'b00, 2'b00, 1'b0);
        step(7'b0000000, 2'b00, 2'b00, 1'b1);

        // Enough short episodes to saturate the 4-bit counter.
        for (int k = 0; k < 20; k++) begin
            repeat (2) step(7'b0000001, 2'b00, 2'b00, 1'b0);
            step(7'b0000000, 2'b00, 2'b00, 1'b0);
        end

        // Random bursts with occasional clear pulses.
        for (int b = 0; b < 60; b++) begin
            len = $urandom_range(1, 7);
            if ($urandom_range(0, 9) < 3) begin
                a  = '0;
                bb = '0;
                ii = '0;
            end else begin
                a  = 7'(1 << $urandom_range(0, 6));
                if ($urandom_range(0, 3) == 0) a = a | 7'($urandom);
                bb = 2'($urandom);
                ii = 2'($urandom);
            end
            for (int k = 0; k < len; k++) step(a, bb, ii, $urandom_range(0, 19) == 0);
        end

        // Asynchronous reset in the middle of a suspect run.
        step(7'b0000000, 2'b00, 2'b00, 1'b1);
        repeat (2) step(7'b0001000, 2'b00, 2'b00, 1'b0);
        @(negedge clock);
        rst_n = 1'b0;
        axis  = '0;
        iblk  = '0;
        iidle = '0;
        clr   = 1'b0;
        #1 check_all_zero("async_reset");
        ms = '{in_dl: 0, run: 0, first: 0, ev: 0};
        mn = ms;
        @(negedge clock);
        rst_n = 1'b1;

        repeat (6) step(7'b0010000, 2'b00, 2'b00, 1'b0);
        step(7'b0000000, 2'b00, 2'b00, 1'b0);

        repeat (3) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
